// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory port arbiter.
//   MDT_*    : MemDataType encodings carried on cpu_type/dma_type/mem_type
//   state_t  : arbiter mode (normal CPU priority / one forced DMA cycle)
//   grant_t  : which requester owns the memory port this cycle
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam logic [2:0] MDT_B  = 3'b000;
  localparam logic [2:0] MDT_H  = 3'b001;
  localparam logic [2:0] MDT_W  = 3'b010;
  localparam logic [2:0] MDT_BU = 3'b100;
  localparam logic [2:0] MDT_HU = 3'b101;

  typedef enum logic [0:0] {
    S_NORM  = 1'b0,
    S_FORCE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2
  } grant_t;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// dmem_arb_starve_ctr
// Counts consecutive cycles in which the DMA request is pending but refused,
// and raises S_FORCE for exactly one cycle once that count reaches
// STARVE_LIMIT. Only instantiated when DMEM_ARB_STARVE_EN is defined.
// Ports:
//   CPU_clk, CPU_rst_n : clock, asynchronous active-low reset
//   dma_valid_i        : DMA request pending
//   dma_ready_i        : DMA granted this cycle
//   state_o            : registered arbiter mode (S_NORM / S_FORCE)
// -----------------------------------------------------------------------------
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic   CPU_clk,
  input  logic   CPU_rst_n,
  input  logic   dma_valid_i,
  input  logic   dma_ready_i,
  output state_t state_o
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    cnt_d   = cnt_q;
    state_d = S_NORM;
    if (state_q == S_FORCE) begin
      // The forced slot lasts one cycle whatever happened in it.
      cnt_d = '0;
    end else if (!dma_valid_i || dma_ready_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == S_NORM && cnt_d == LIMIT) begin
      state_d = S_FORCE;
    end
  end

  // NOTE: state uses non-blocking assignments and an asynchronous active-low
  // reset, so all flops update together on the edge and clear immediately.
  always_ff @(posedge CPU_clk or negedge CPU_rst_n) begin
    if (!CPU_rst_n) begin
      cnt_q   <= '0;
      state_q <= S_NORM;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares the single data-memory port between the CPU load/store path and a
// DMA/debug master. The CPU wins by default so the single-cycle datapath sees
// zero-latency access; the DMA uses idle slots.
// Build option: define DMEM_ARB_STARVE_EN to add the starvation counter that
// forces one DMA cycle (stalling the CPU) after STARVE_LIMIT refused cycles.
// Without it the CPU has strict priority and cpu_stall is tied low.
// Ports:
//   CPU_clk, CPU_rst_n                       : clock, async active-low reset
//   cpu_rd/wr/type/addr/wdata -> cpu_rdata   : CPU request, same-cycle data
//   cpu_stall                                : CPU must hold this cycle
//   dma_valid/we/type/addr/wdata, dma_ready  : DMA valid/ready request
//   dma_rvalid, dma_rdata                    : registered DMA load return
//   mem_read/write/type/addr/wdata, mem_rdata: data-memory port
// -----------------------------------------------------------------------------
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic             CPU_clk,
  input  logic             CPU_rst_n,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [2:0]       cpu_type,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             dma_valid,
  input  logic             dma_we,
  input  logic [2:0]       dma_type,
  input  logic [WIDTH-1:0] dma_addr,
  input  logic [WIDTH-1:0] dma_wdata,
  output logic             dma_ready,
  output logic             dma_rvalid,
  output logic [WIDTH-1:0] dma_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [2:0]       mem_type,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  if (STARVE_LIMIT == 0) begin : g_limit_chk
    $error("dmem_port_arbiter: STARVE_LIMIT must be >= 1");
  end

  state_t           state;
  grant_t           gnt;
  logic             cpu_req;
  logic             dma_rvalid_d;
  logic [WIDTH-1:0] dma_rdata_d;

  // rd and wr together is illegal and counts as no request.
  assign cpu_req = cpu_rd ^ cpu_wr;

`ifdef DMEM_ARB_STARVE_EN
  dmem_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .CPU_clk     (CPU_clk),
    .CPU_rst_n   (CPU_rst_n),
    .dma_valid_i (dma_valid),
    .dma_ready_i (dma_ready),
    .state_o     (state)
  );
`else
  assign state = S_NORM;
`endif

  // Grant selection. Everything is held off while reset is asserted so the
  // memory never sees a stray access during reset.
  always_comb begin
    gnt       = GNT_NONE;
    cpu_stall = 1'b0;
    if (!CPU_rst_n) begin
      gnt = GNT_NONE;
    end else if (state == S_FORCE && dma_valid) begin
      gnt       = GNT_DMA;
      cpu_stall = cpu_req;
    end else if (cpu_req) begin
      gnt = GNT_CPU;
    end else if (dma_valid) begin
      gnt = GNT_DMA;
    end
  end

  // Memory port mux; an idle port drives all zeros.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_type  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    dma_ready = 1'b0;
    unique case (gnt)
      GNT_CPU: begin
        mem_read  = cpu_rd;
        mem_write = cpu_wr;
        mem_type  = cpu_type;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_rdata = mem_rdata;
      end
      GNT_DMA: begin
        mem_read  = ~dma_we;
        mem_write = dma_we;
        mem_type  = dma_type;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        dma_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // DMA load return: capture on the edge that ends a load handshake; the data
  // stays put until the next DMA load, stores never pulse dma_rvalid.
  assign dma_rvalid_d = (gnt == GNT_DMA) && !dma_we;
  assign dma_rdata_d  = dma_rvalid_d ? mem_rdata : dma_rdata;

  always_ff @(posedge CPU_clk or negedge CPU_rst_n) begin
    if (!CPU_rst_n) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_rvalid_d;
      dma_rdata  <= dma_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Self-checking bench for dmem_port_arbiter. Inputs change 1 ns after the
// rising edge, outputs are compared 4 ns later (mid-cycle). A behavioural
// model (grant rules, starvation count, DMA load return) tracks every cycle.
// Build option: DMEM_ARB_STARVE_EN selects the starvation-enabled checks.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int W     = 32;
  localparam int LIMIT = 8;

  logic         CPU_clk = 1'b0;
  logic         CPU_rst_n;
  logic         cpu_rd, cpu_wr;
  logic [2:0]   cpu_type;
  logic [W-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_stall;
  logic         dma_valid, dma_we;
  logic [2:0]   dma_type;
  logic [W-1:0] dma_addr, dma_wdata;
  logic         dma_ready, dma_rvalid;
  logic [W-1:0] dma_rdata;
  logic         mem_read, mem_write;
  logic [2:0]   mem_type;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

  dmem_port_arbiter #(
    .WIDTH        (W),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .CPU_clk    (CPU_clk),
    .CPU_rst_n  (CPU_rst_n),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_type   (cpu_type),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_valid  (dma_valid),
    .dma_we     (dma_we),
    .dma_type   (dma_type),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_ready  (dma_ready),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_type   (mem_type),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 CPU_clk = ~CPU_clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int           m_starve = 0;
  bit           m_force  = 1'b0;
  bit           m_rvalid = 1'b0;
  logic [W-1:0] m_rdata  = '0;

  // 0 = nobody, 1 = CPU, 2 = DMA
  function automatic int exp_grant();
    bit creq = cpu_rd ^ cpu_wr;
    if (!CPU_rst_n)           return 0;
    if (m_force && dma_valid) return 2;
    if (creq)                 return 1;
    if (dma_valid)            return 2;
    return 0;
  endfunction

  // Advance the model across one rising edge using the inputs of the cycle.
  task automatic tick();
    int g = exp_grant();
    if (g == 2 && !dma_we) begin
      m_rvalid = 1'b1;
      m_rdata  = mem_rdata;
    end else begin
      m_rvalid = 1'b0;
    end
`ifdef DMEM_ARB_STARVE_EN
    if (m_force) begin
      m_force  = 1'b0;
      m_starve = 0;
    end else begin
      if (dma_valid && g != 2) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else                     m_starve = 0;
      m_force = (m_starve == LIMIT);
    end
`endif
    @(posedge CPU_clk);
    if (!CPU_rst_n) begin
      m_rvalid = 1'b0;
      m_rdata  = '0;
      m_starve = 0;
      m_force  = 1'b0;
    end
    #1;
  endtask

  task automatic drive_idle();
    cpu_rd = 0; cpu_wr = 0; cpu_type = '0; cpu_addr = '0; cpu_wdata = '0;
    dma_valid = 0; dma_we = 0; dma_type = '0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0;
  endtask

  task automatic test_reset();
    CPU_rst_n = 1'b0;
    cpu_rd = 1; dma_valid = 1; dma_we = 0; mem_rdata = 32'h1234_5678;
    #4;
    total++;
    if ({dma_ready, cpu_stall, mem_read, mem_write} !== 4'b0000) begin
      bad++;
      $display("FAIL reset.ctrl got=%b expected=0000", {dma_ready, cpu_stall, mem_read, mem_write});
    end
    total++;
    if (dma_rvalid !== 1'b0) begin
      bad++; $display("FAIL reset.dma_rvalid got=%b expected=0", dma_rvalid);
    end
    total++;
    if (dma_rdata !== '0) begin
      bad++; $display("FAIL reset.dma_rdata got=%h expected=0", dma_rdata);
    end
    total++;
    if (cpu_rdata !== '0) begin
      bad++; $display("FAIL reset.cpu_rdata got=%h expected=0", cpu_rdata);
    end
    tick();
    tick();
    CPU_rst_n = 1'b1;
    drive_idle();
    #4;
    total++;
    if ({dma_ready, mem_read, mem_write, dma_rvalid} !== 4'b0000) begin
      bad++;
      $display("FAIL reset.idle got=%b expected=0000", {dma_ready, mem_read, mem_write, dma_rvalid});
    end
    tick();
  endtask

  task automatic test_cpu_only();
    drive_idle();
    cpu_rd = 1; cpu_type = 3'b010; cpu_addr = 32'h40; mem_rdata = 32'hA5A5_0F0F;
    #4;
    total++;
    if ({mem_read, mem_write, dma_ready, cpu_stall} !== 4'b1000) begin
      bad++;
      $display("FAIL cpu_only.ctrl got=%b expected=1000", {mem_read, mem_write, dma_ready, cpu_stall});
    end
    total++;
    if (mem_addr !== 32'h40 || mem_type !== 3'b010) begin
      bad++; $display("FAIL cpu_only.addr got=%h/%b expected=40/010", mem_addr, mem_type);
    end
    total++;
    if (cpu_rdata !== 32'hA5A5_0F0F) begin
      bad++; $display("FAIL cpu_only.cpu_rdata got=%h expected=a5a50f0f", cpu_rdata);
    end
    tick();
  endtask

  task automatic test_dma_idle();
    drive_idle();
    dma_valid = 1; dma_we = 0; dma_type = 3'b010; dma_addr = 32'h80; mem_rdata = 32'hDEAD_BEEF;
    #4;
    total++;
    if ({dma_ready, mem_read, mem_write} !== 3'b110 || mem_addr !== 32'h80) begin
      bad++;
      $display("FAIL dma_idle.grant got=%b addr=%h expected=110 addr=80", {dma_ready, mem_read, mem_write}, mem_addr);
    end
    total++;
    if (cpu_rdata !== '0) begin
      bad++; $display("FAIL dma_idle.cpu_rdata got=%h expected=0", cpu_rdata);
    end
    tick();
    // DMA store right after: the load result must appear, the store must not pulse.
    dma_we = 1; dma_wdata = 32'h0BAD_F00D; mem_rdata = 32'h1111_2222;
    #4;
    total++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL dma_idle.load_ret got=%b/%h expected=1/deadbeef", dma_rvalid, dma_rdata);
    end
    total++;
    if (mem_write !== 1'b1 || mem_wdata !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL dma_idle.store got=%b/%h expected=1/0badf00d", mem_write, mem_wdata);
    end
    tick();
    drive_idle();
    #4;
    total++;
    if (dma_rvalid !== 1'b0 || dma_rdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL dma_idle.store_noret got=%b/%h expected=0/deadbeef", dma_rvalid, dma_rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    drive_idle();
    #4;
    tick();
    cpu_wr = 1; cpu_addr = 32'h200; cpu_wdata = 32'h5555_AAAA; cpu_type = 3'b010;
    dma_valid = 1; dma_we = 0; dma_addr = 32'h100;
`ifdef DMEM_ARB_STARVE_EN
    for (int i = 0; i < 2 * (LIMIT + 1); i++) begin
      bit f = (i % (LIMIT + 1)) == LIMIT;
      mem_rdata = $urandom;
      #4;
      total++;
      if ({cpu_stall, dma_ready, mem_read, mem_write} !== {f, f, f, !f}) begin
        bad++;
        $display("FAIL contention.cyc%0d got=%b expected=%b", i,
                 {cpu_stall, dma_ready, mem_read, mem_write}, {f, f, f, !f});
      end
      tick();
    end
`else
    for (int i = 0; i < 50; i++) begin
      #4;
      total++;
      if ({cpu_stall, dma_ready, mem_write} !== 3'b001) begin
        bad++;
        $display("FAIL strict_prio.cyc%0d got=%b expected=001", i, {cpu_stall, dma_ready, mem_write});
      end
      tick();
    end
`endif
    drive_idle();
    #4;
    tick();
  endtask

  task automatic test_illegal();
    for (int k = 0; k < 2; k++) begin
      drive_idle();
      cpu_rd = 1; cpu_wr = 1; dma_valid = 1; dma_we = k[0]; dma_addr = 32'h300 + k;
      #4;
      total++;
      if ({dma_ready, mem_read, mem_write, cpu_stall} !== {1'b1, ~k[0], k[0], 1'b0} || mem_addr !== 32'h300 + k) begin
        bad++;
        $display("FAIL illegal.we%0d got=%b addr=%h", k, {dma_ready, mem_read, mem_write, cpu_stall}, mem_addr);
      end
      tick();
    end
    drive_idle();
    #4;
    tick();
  endtask

  task automatic test_random();
    bit hs = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 7);
      int g;
      logic [4:0]   ef;
      logic [W-1:0] ea, ew, er;
      logic [2:0]   et;
      cpu_rd = (r >= 2 && r <= 4) || r == 7;
      cpu_wr = (r >= 5);
      cpu_type = 3'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
      if (!(dma_valid && !hs)) begin
        dma_valid = $urandom_range(0, 1);
        dma_we = $urandom_range(0, 1);
        dma_type = 3'($urandom); dma_addr = $urandom; dma_wdata = $urandom;
      end
      mem_rdata = $urandom;
      #4;
      g  = exp_grant();
      ef = {g == 2, m_force && dma_valid && (cpu_rd ^ cpu_wr),
            (g == 1) ? cpu_rd : (g == 2) ? !dma_we : 1'b0,
            (g == 1) ? cpu_wr : (g == 2) ? dma_we : 1'b0, m_rvalid};
      ea = (g == 1) ? cpu_addr  : (g == 2) ? dma_addr  : '0;
      ew = (g == 1) ? cpu_wdata : (g == 2) ? dma_wdata : '0;
      et = (g == 1) ? cpu_type  : (g == 2) ? dma_type  : 3'b000;
      er = (g == 1) ? mem_rdata : '0;
      total++;
      if ({dma_ready, cpu_stall, mem_read, mem_write, dma_rvalid} !== ef) begin
        bad++;
        $display("FAIL random.ctrl cyc%0d got=%b expected=%b", i,
                 {dma_ready, cpu_stall, mem_read, mem_write, dma_rvalid}, ef);
      end
      total++;
      if (mem_addr !== ea || mem_wdata !== ew || mem_type !== et) begin
        bad++;
        $display("FAIL random.port cyc%0d got=%h/%h/%b expected=%h/%h/%b", i,
                 mem_addr, mem_wdata, mem_type, ea, ew, et);
      end
      total++;
      if (cpu_rdata !== er || dma_rdata !== m_rdata) begin
        bad++;
        $display("FAIL random.rdata cyc%0d got=%h/%h expected=%h/%h", i,
                 cpu_rdata, dma_rdata, er, m_rdata);
      end
      hs = dma_valid && dma_ready;
      tick();
    end
    drive_idle();
    #4;
    tick();
  endtask

  task automatic test_reset_mid();
    drive_idle();
    dma_valid = 1; dma_we = 0; dma_addr = 32'h80; mem_rdata = 32'hCAFE_F00D;
    #4;
    total++;
    if (dma_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid.pre_ready got=%b expected=1", dma_ready);
    end
    #2;
    CPU_rst_n = 1'b0;
    #1;
    total++;
    if ({dma_ready, mem_read} !== 2'b00) begin
      bad++; $display("FAIL reset_mid.ready_drop got=%b expected=00", {dma_ready, mem_read});
    end
    tick();
    total++;
    if (dma_rvalid !== 1'b0 || dma_rdata !== '0) begin
      bad++; $display("FAIL reset_mid.dropped got=%b/%h expected=0/0", dma_rvalid, dma_rdata);
    end
    drive_idle();
    CPU_rst_n = 1'b1;
    #4;
    tick();
`ifdef DMEM_ARB_STARVE_EN
    // Build up a partial starvation count, reset, then the full limit must elapse.
    cpu_wr = 1; dma_valid = 1; dma_we = 1;
    for (int i = 0; i < 5; i++) begin
      #4;
      tick();
    end
    CPU_rst_n = 1'b0;
    tick();
    CPU_rst_n = 1'b1;
    for (int i = 0; i <= LIMIT; i++) begin
      bit f = (i == LIMIT);
      #4;
      total++;
      if ({cpu_stall, dma_ready} !== {f, f}) begin
        bad++; $display("FAIL reset_mid.cnt_clr cyc%0d got=%b expected=%b", i, {cpu_stall, dma_ready}, {f, f});
      end
      tick();
    end
    drive_idle();
    #4;
    tick();
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    CPU_rst_n = 1'b0;
    drive_idle();
    @(posedge CPU_clk);
    #1;
    test_reset();
    test_cpu_only();
    test_dma_idle();
    test_contention();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
